// File: rtl/dc_err_reporter.sv
// Data-concentrator error reporter: after in_live rises it waits, scans each channel once and issues one verdict strobe.
// Optional macro DC_ERR_RETRY_EN adds a single delayed rescan when the first scan reaches the error threshold.
module dc_err_reporter #(
    parameter int NCH        = 16,
    parameter int SETTLE_CYC = 32,
    parameter int ERR_THRESH = 1,
    parameter int RETRY_CYC  = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_live,
    input  logic [NCH-1:0] ch_err,
    input  logic [NCH-1:0] ch_valid,
    output logic           got_dc_err,
    output logic           is_dc_err,
    output logic [7:0]     err_count,
    output logic           busy
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] IDX_LAST   = IW'(NCH - 1);
    localparam logic [15:0]   SETTLE_END = 16'(SETTLE_CYC - 1);
    localparam logic [7:0]    THR        = 8'(ERR_THRESH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_SCAN   = 3'd2;
    localparam logic [2:0] S_RETRY  = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    generate
        if (NCH < 1 || NCH > 255) begin : g_bad_nch
            $error("dc_err_reporter: NCH out of range");
        end
        if (SETTLE_CYC < 1 || SETTLE_CYC > 65535) begin : g_bad_settle
            $error("dc_err_reporter: SETTLE_CYC out of range");
        end
        if (ERR_THRESH < 1 || ERR_THRESH > NCH) begin : g_bad_thresh
            $error("dc_err_reporter: ERR_THRESH out of range");
        end
        if (RETRY_CYC < 1 || RETRY_CYC > 65535) begin : g_bad_retry
            $error("dc_err_reporter: RETRY_CYC out of range");
        end
    endgenerate

    logic [2:0]    r_state;
    logic [15:0]   r_cnt;
    logic [IW-1:0] r_idx;
    logic [7:0]    r_acc;
    logic          r_live_d;
    logic          r_is_err;
    logic [7:0]    r_err_count;

    logic          w_rise;
    logic          w_bad;
    logic          w_last;
    logic [7:0]    w_acc_nxt;

`ifdef DC_ERR_RETRY_EN
    localparam logic [15:0] RETRY_END = 16'(RETRY_CYC - 1);
    logic r_retried;
`endif

    assign w_rise    = in_live & ~r_live_d;
    assign w_bad     = ch_err[r_idx] | ~ch_valid[r_idx];
    assign w_last    = (r_idx == IDX_LAST);
    // Saturating accumulate; the saturation only matters if NCH is widened past 255.
    assign w_acc_nxt = (w_bad && r_acc != 8'hFF) ? r_acc + 8'd1 : r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_live_d    <= 1'b1;
            r_is_err    <= 1'b1;
            r_err_count <= '0;
`ifdef DC_ERR_RETRY_EN
            r_retried   <= 1'b0;
`endif
        end else begin
            r_live_d <= in_live;
            case (r_state)
                S_IDLE: begin
                    r_is_err <= 1'b1;
`ifdef DC_ERR_RETRY_EN
                    r_retried <= 1'b0;
`endif
                    if (w_rise) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= '0;
                    end
                end
                S_SETTLE: begin
                    if (!in_live) begin
                        r_state  <= S_IDLE;
                        r_is_err <= 1'b1;
                    end else if (r_cnt == SETTLE_END) begin
                        r_state <= S_SCAN;
                        r_idx   <= '0;
                        r_acc   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_SCAN: begin
                    if (!in_live) begin
                        r_state  <= S_IDLE;
                        r_is_err <= 1'b1;
                    end else begin
                        r_acc <= w_acc_nxt;
                        if (!w_last) begin
                            r_idx <= r_idx + 1'b1;
`ifdef DC_ERR_RETRY_EN
                        end else if (w_acc_nxt >= THR && !r_retried) begin
                            r_state   <= S_RETRY;
                            r_cnt     <= '0;
                            r_retried <= 1'b1;
`endif
                        end else begin
                            // Verdict registered here so it is valid during the strobe cycle.
                            r_state     <= S_REPORT;
                            r_is_err    <= (w_acc_nxt >= THR);
                            r_err_count <= w_acc_nxt;
                        end
                    end
                end
`ifdef DC_ERR_RETRY_EN
                S_RETRY: begin
                    if (!in_live) begin
                        r_state  <= S_IDLE;
                        r_is_err <= 1'b1;
                    end else if (r_cnt == RETRY_END) begin
                        r_state <= S_SCAN;
                        r_idx   <= '0;
                        r_acc   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
`endif
                S_REPORT: r_state <= S_DONE;
                S_DONE: begin
                    if (!in_live) begin
                        r_state  <= S_IDLE;
                        r_is_err <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign got_dc_err = (r_state == S_REPORT);
    assign is_dc_err  = r_is_err;
    assign err_count  = r_err_count;
    assign busy       = (r_state == S_SETTLE) || (r_state == S_SCAN) || (r_state == S_RETRY);

endmodule

// File: tb/tb_dc_err_reporter.sv
// Bench for dc_err_reporter (default build): randomized live periods checked against a timing/count reference model.
module tb_dc_err_reporter;

    localparam int S = 32;
    localparam int N = 16;
    localparam int R = S + N + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_live;
    logic [N-1:0] ch_err;
    logic [N-1:0] ch_valid;
    logic         got, is_err, busy;
    logic [7:0]   cnt;
    logic         got3, is_err3, busy3;
    logic [7:0]   cnt3;

    int       n_tests = 0;
    int       n_fail  = 0;
    logic [7:0] m_cnt = 8'd0;

    always #5 clk = ~clk;

    dc_err_reporter #(.NCH(N), .SETTLE_CYC(S), .ERR_THRESH(1), .RETRY_CYC(64)) dut (
        .clk(clk), .rst(rst), .in_live(in_live), .ch_err(ch_err), .ch_valid(ch_valid),
        .got_dc_err(got), .is_dc_err(is_err), .err_count(cnt), .busy(busy)
    );

    dc_err_reporter #(.NCH(N), .SETTLE_CYC(S), .ERR_THRESH(3), .RETRY_CYC(64)) dut3 (
        .clk(clk), .rst(rst), .in_live(in_live), .ch_err(ch_err), .ch_valid(ch_valid),
        .got_dc_err(got3), .is_dc_err(is_err3), .err_count(cnt3), .busy(busy3)
    );

    task automatic set_chan(input int mode, input int k);
        logic [N-1:0] e, v;
        e = '0;
        v = '1;
        case (mode)
            1: begin e[9] = 1'b1; v[5] = 1'b0; end
            2: for (int b = 0; b < N; b++) begin
                   e[b] = ($urandom_range(0, 7) == 0);
                   v[b] = ($urandom_range(0, 9) != 0);
               end
            3: if (k >= S + 1 && k <= S + N) e[3] = 1'b1;
            default: ;
        endcase
        ch_err   = e;
        ch_valid = v;
    endtask

    // One live period of len cycles followed by gap low cycles; period 0 is the first high cycle.
    task automatic drive_live(input int len, input int gap, input int mode,
                              output int got_n, output int got_off,
                              output logic is_g, output logic is3_g, output logic [7:0] cnt_g,
                              output int exp_cnt, output int mis);
        bit rep;
        logic e_busy, e_is, e_is3, e_got;
        got_n = 0; got_off = -1; is_g = 1'bx; is3_g = 1'bx; cnt_g = 8'hxx;
        exp_cnt = 0; mis = 0;
        rep = (len > S + N);
        for (int k = 0; k < len + gap; k++) begin
            in_live = (k < len);
            set_chan(mode, k);
            if (k >= S + 1 && k <= S + N)
                if (ch_err[k-S-1] || !ch_valid[k-S-1]) exp_cnt++;
            #5;
            e_got  = rep && (k == R);
            e_busy = (k >= 1) && (k <= S + N) && (k <= len);
            if (rep && k >= R && k <= ((len > R + 1) ? len : R + 1)) begin
                e_is  = (exp_cnt >= 1);
                e_is3 = (exp_cnt >= 3);
            end else begin
                e_is  = 1'b1;
                e_is3 = 1'b1;
            end
            if (e_got) m_cnt = 8'(exp_cnt);
            if (got) begin
                got_n++;
                if (got_off < 0) begin
                    got_off = k; is_g = is_err; is3_g = is_err3; cnt_g = cnt;
                end
            end
            if (got !== e_got || got3 !== e_got || busy !== e_busy || busy3 !== e_busy ||
                is_err !== e_is || is_err3 !== e_is3 || cnt !== m_cnt || cnt3 !== m_cnt)
                mis++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_live = 1'b0; ch_err = '0; ch_valid = '1;
        repeat (3) begin @(posedge clk); #1; end
        #5;
        n_tests++; if (got !== 1'b0)   begin n_fail++; $display("FAIL reset_got: got %b expected 0", got); end
        n_tests++; if (is_err !== 1'b1) begin n_fail++; $display("FAIL reset_is: got %b expected 1", is_err); end
        n_tests++; if (cnt !== 8'd0)   begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
        n_tests++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        m_cnt = 8'd0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic test_clean();
        int gn, go, ec, mis; logic ig, ig3; logic [7:0] cg;
        drive_live(60, 4, 0, gn, go, ig, ig3, cg, ec, mis);
        n_tests++; if (gn !== 1)     begin n_fail++; $display("FAIL clean_pulses: got %0d expected 1", gn); end
        n_tests++; if (go !== 49)    begin n_fail++; $display("FAIL clean_latency: got %0d expected 49", go); end
        n_tests++; if (ig !== 1'b0)  begin n_fail++; $display("FAIL clean_is: got %b expected 0", ig); end
        n_tests++; if (cg !== 8'd0)  begin n_fail++; $display("FAIL clean_cnt: got %0d expected 0", cg); end
        n_tests++; if (mis !== 0)    begin n_fail++; $display("FAIL clean_trace: %0d cycles differ from model, expected 0", mis); end
    endtask

    task automatic test_bad_channels();
        int gn, go, ec, mis; logic ig, ig3; logic [7:0] cg;
        drive_live(60, 4, 1, gn, go, ig, ig3, cg, ec, mis);
        n_tests++; if (go !== 49)    begin n_fail++; $display("FAIL bad_latency: got %0d expected 49", go); end
        n_tests++; if (cg !== 8'd2)  begin n_fail++; $display("FAIL bad_cnt: got %0d expected 2", cg); end
        n_tests++; if (ig !== 1'b1)  begin n_fail++; $display("FAIL bad_is: got %b expected 1", ig); end
        n_tests++; if (ig3 !== 1'b0) begin n_fail++; $display("FAIL bad_is_thresh3: got %b expected 0", ig3); end
        n_tests++; if (mis !== 0)    begin n_fail++; $display("FAIL bad_trace: %0d cycles differ from model, expected 0", mis); end
    endtask

    task automatic test_abort();
        int gn, go, ec, mis; logic ig, ig3; logic [7:0] cg;
        drive_live(40, 4, 0, gn, go, ig, ig3, cg, ec, mis);
        n_tests++; if (gn !== 0)     begin n_fail++; $display("FAIL abort_pulses: got %0d expected 0", gn); end
        n_tests++; if (mis !== 0)    begin n_fail++; $display("FAIL abort_trace: %0d cycles differ from model, expected 0", mis); end
        n_tests++; if (cnt !== 8'd2) begin n_fail++; $display("FAIL abort_cnt_held: got %0d expected 2", cnt); end
        drive_live(60, 4, 0, gn, go, ig, ig3, cg, ec, mis);
        n_tests++; if (go !== 49)    begin n_fail++; $display("FAIL abort_next_latency: got %0d expected 49", go); end
        n_tests++; if (ig !== 1'b0)  begin n_fail++; $display("FAIL abort_next_is: got %b expected 0", ig); end
    endtask

    task automatic test_retry_off();
        int gn, go, ec, mis; logic ig, ig3; logic [7:0] cg;
        drive_live(60, 4, 3, gn, go, ig, ig3, cg, ec, mis);
        n_tests++; if (go !== 49)    begin n_fail++; $display("FAIL noretry_latency: got %0d expected 49", go); end
        n_tests++; if (ig !== 1'b1)  begin n_fail++; $display("FAIL noretry_is: got %b expected 1", ig); end
        n_tests++; if (cg !== 8'd1)  begin n_fail++; $display("FAIL noretry_cnt: got %0d expected 1", cg); end
    endtask

    task automatic test_reset_midlive();
        int gn, go, ec, mis, pulses; logic ig, ig3; logic [7:0] cg;
        pulses = 0;
        for (int k = 0; k < 120; k++) begin
            in_live = 1'b1;
            rst = (k == 20);
            set_chan(2, k);
            #5;
            if (got) pulses++;
            if (k == 21) begin
                n_tests++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
                n_tests++; if (is_err !== 1'b1) begin n_fail++; $display("FAIL rstmid_is: got %b expected 1", is_err); end
                n_tests++; if (cnt !== 8'd0)    begin n_fail++; $display("FAIL rstmid_cnt: got %0d expected 0", cnt); end
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        m_cnt = 8'd0;
        n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL rstmid_pulses: got %0d expected 0", pulses); end
        in_live = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        drive_live(60, 4, 0, gn, go, ig, ig3, cg, ec, mis);
        n_tests++; if (go !== 49)  begin n_fail++; $display("FAIL rstmid_next_latency: got %0d expected 49", go); end
        n_tests++; if (mis !== 0)  begin n_fail++; $display("FAIL rstmid_next_trace: %0d cycles differ from model, expected 0", mis); end
    endtask

    task automatic test_single_strobe();
        int gn, go, ec, mis; logic ig, ig3; logic [7:0] cg;
        drive_live(10000, 4, 2, gn, go, ig, ig3, cg, ec, mis);
        n_tests++; if (gn !== 1)         begin n_fail++; $display("FAIL strobe_pulses: got %0d expected 1", gn); end
        n_tests++; if (cg !== 8'(ec))    begin n_fail++; $display("FAIL strobe_cnt: got %0d expected %0d", cg, ec); end
        n_tests++; if (mis !== 0)        begin n_fail++; $display("FAIL strobe_trace: %0d cycles differ from model, expected 0", mis); end
    endtask

    task automatic test_random();
        int gn, go, ec, mis, len, gap; logic ig, ig3; logic [7:0] cg;
        for (int it = 0; it < 12; it++) begin
            len = $urandom_range(5, 110);
            gap = $urandom_range(3, 6);
            drive_live(len, gap, 2, gn, go, ig, ig3, cg, ec, mis);
            n_tests++;
            if (gn !== ((len > S + N) ? 1 : 0)) begin
                n_fail++; $display("FAIL rand_pulses[%0d] len=%0d: got %0d expected %0d", it, len, gn, (len > S + N) ? 1 : 0);
            end
            n_tests++;
            if (mis !== 0) begin
                n_fail++; $display("FAIL rand_trace[%0d] len=%0d: %0d cycles differ from model, expected 0", it, len, mis);
            end
            if (gn == 1) begin
                n_tests++;
                if (cg !== 8'(ec) || ig !== (ec >= 1)) begin
                    n_fail++; $display("FAIL rand_report[%0d]: cnt=%0d is=%b expected cnt=%0d is=%b", it, cg, ig, ec, ec >= 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_bad_channels();
        test_abort();
        test_retry_off();
        test_reset_midlive();
        test_single_strobe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
